// File: rtl/pcie_io_tx_engine.sv
// pcie_io_tx_engine
//   Completion generator that sits downstream of the PCIe IO RX engine.
//   A non-posted request finishes when RX holds i_req_compl and memory returns
//   i_resp_mem_valid. At that point the engine captures the request fields and
//   the addressed read-data DW. It then sends a 3DW Cpl or CplD TLP as two
//   64-bit AXI-Stream beats and pulses o_compl_done for one cycle to release RX.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   o_s_axis_tx_*           AXIS TX master toward the PCIe core
//                           (tdata/tkeep/tlast/tvalid registered, tuser tied 0)
//   i_s_axis_tx_tready      core accepts the current beat
//   i_req_compl             completion required (level from RX)
//   i_req_compl_wd          1 = CplD carrying one DW, 0 = Cpl without data
//   i_req_tc/td/ep/attr     header fields echoed into DW0
//   i_req_len               request length (single-DW requests only)
//   i_req_rid, i_req_tag    requester ID and tag echoed into DW2
//   i_req_be                [3:0] first byte enables
//   i_req_addr              request byte address
//   i_completer_id          {bus,dev,func} of this function
//   i_resp_mem_valid        memory read response strobe
//   i_resp_mem_data         memory read data (two DWs)
//   o_compl_done            one-cycle pulse once the last beat is accepted
module pcie_io_tx_engine #(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    output logic [C_DATA_WIDTH-1:0] o_s_axis_tx_tdata,
    output logic [KEEP_WIDTH-1:0]   o_s_axis_tx_tkeep,
    output logic                    o_s_axis_tx_tlast,
    output logic                    o_s_axis_tx_tvalid,
    input  logic                    i_s_axis_tx_tready,
    output logic [3:0]              o_s_axis_tx_tuser,
    input  logic                    i_req_compl,
    input  logic                    i_req_compl_wd,
    output logic                    o_compl_done,
    input  logic [2:0]              i_req_tc,
    input  logic                    i_req_td,
    input  logic                    i_req_ep,
    input  logic [1:0]              i_req_attr,
    input  logic [9:0]              i_req_len,
    input  logic [15:0]             i_req_rid,
    input  logic [7:0]              i_req_tag,
    input  logic [7:0]              i_req_be,
    input  logic [12:0]             i_req_addr,
    input  logic [15:0]             i_completer_id,
    input  logic                    i_resp_mem_valid,
    input  logic [63:0]             i_resp_mem_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Memory returns bytes in bus order; the TLP payload wants them reversed.
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Number of bytes spanned from the lowest to the highest enabled byte.
    function automatic logic [11:0] first_be_byte_count(input logic [3:0] be);
        logic [11:0] bc;
        casez (be)
            4'b1??1:                   bc = 12'd4;
            4'b01?1, 4'b1?10:          bc = 12'd3;
            4'b0011, 4'b0110, 4'b1100: bc = 12'd2;
            default:                   bc = 12'd1;
        endcase
        return bc;
    endfunction

    state_t      state_r;
    logic        compl_wd_r;
    logic [15:0] rid_r;
    logic [7:0]  tag_r;
    logic [6:0]  lower_addr_r;
    logic [31:0] data_dw_r;

    logic        trigger_s;
    logic [1:0]  fmt_s;
    logic [9:0]  len_s;
    logic [11:0] byte_count_s;
    logic [31:0] dw0_s;
    logic [31:0] dw1_s;
    logic [31:0] dw2_s;
    logic [6:0]  lower_addr_s;
    logic [31:0] data_dw_s;
    logic        unused_s;

    // Length is always one DW for CplD, so the request length, the last BE
    // and the upper address bits carry no information for the completion.
    assign unused_s = ^{i_req_len, i_req_be[7:4], i_req_addr[12:7]};

    assign trigger_s    = (state_r == ST_IDLE) && i_req_compl && i_resp_mem_valid;
    assign fmt_s        = i_req_compl_wd ? 2'b10 : 2'b00;
    assign len_s        = i_req_compl_wd ? 10'd1 : 10'd0;
    assign byte_count_s = i_req_compl_wd ? first_be_byte_count(i_req_be[3:0]) : 12'd4;
    // RX already folds the first-BE offset into addr[1:0].
    assign lower_addr_s = i_req_compl_wd ? i_req_addr[6:0] : 7'h00;
    assign data_dw_s    = byte_swap32(i_req_addr[2] ? i_resp_mem_data[63:32]
                                                    : i_resp_mem_data[31:0]);

    assign dw0_s = {1'b0, fmt_s, 5'b01010, 1'b0, i_req_tc, 4'b0000,
                    i_req_td, i_req_ep, i_req_attr, 2'b00, len_s};
    assign dw1_s = {i_completer_id, 3'b000, 1'b0, byte_count_s};
    assign dw2_s = {rid_r, tag_r, 1'b0, lower_addr_r};

    assign o_s_axis_tx_tuser = 4'b0000;

    // Completion FSM: captures the request, drives both beats, pulses done.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r            <= ST_IDLE;
            o_s_axis_tx_tdata  <= '0;
            o_s_axis_tx_tkeep  <= '0;
            o_s_axis_tx_tlast  <= 1'b0;
            o_s_axis_tx_tvalid <= 1'b0;
            o_compl_done       <= 1'b0;
            compl_wd_r         <= 1'b0;
            rid_r              <= 16'h0000;
            tag_r              <= 8'h00;
            lower_addr_r       <= 7'h00;
            data_dw_r          <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    o_compl_done <= 1'b0;
                    if (trigger_s) begin
                        compl_wd_r         <= i_req_compl_wd;
                        rid_r              <= i_req_rid;
                        tag_r              <= i_req_tag;
                        lower_addr_r       <= lower_addr_s;
                        data_dw_r          <= data_dw_s;
                        // Beat 0 needs only live inputs, so build it now.
                        o_s_axis_tx_tdata  <= {dw1_s, dw0_s};
                        o_s_axis_tx_tkeep  <= 8'hFF;
                        o_s_axis_tx_tlast  <= 1'b0;
                        o_s_axis_tx_tvalid <= 1'b1;
                        state_r            <= ST_BEAT0;
                    end
                end
                ST_BEAT0: begin
                    if (i_s_axis_tx_tready) begin
                        o_s_axis_tx_tdata <= compl_wd_r ? {data_dw_r, dw2_s}
                                                        : {32'h0000_0000, dw2_s};
                        o_s_axis_tx_tkeep <= compl_wd_r ? 8'hFF : 8'h0F;
                        o_s_axis_tx_tlast <= 1'b1;
                        state_r           <= ST_BEAT1;
                    end
                end
                ST_BEAT1: begin
                    if (i_s_axis_tx_tready) begin
                        o_s_axis_tx_tdata  <= '0;
                        o_s_axis_tx_tkeep  <= '0;
                        o_s_axis_tx_tlast  <= 1'b0;
                        o_s_axis_tx_tvalid <= 1'b0;
                        o_compl_done       <= 1'b1;
                        state_r            <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    o_compl_done <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    o_s_axis_tx_tvalid <= 1'b0;
                    o_compl_done       <= 1'b0;
                    state_r            <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_io_tx_engine.sv
// Directed bench for pcie_io_tx_engine with hand-computed completion TLPs.
module tb_pcie_io_tx_engine;

    logic        clk;
    logic        rst;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;
    logic [3:0]  tuser;
    logic        req_compl;
    logic        req_compl_wd;
    logic        compl_done;
    logic [2:0]  req_tc;
    logic        req_td;
    logic        req_ep;
    logic [1:0]  req_attr;
    logic [9:0]  req_len;
    logic [15:0] req_rid;
    logic [7:0]  req_tag;
    logic [7:0]  req_be;
    logic [12:0] req_addr;
    logic [15:0] completer_id;
    logic        mem_valid;
    logic [63:0] mem_data;

    int total;
    int bad;

    pcie_io_tx_engine #(.C_DATA_WIDTH(64), .KEEP_WIDTH(8)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .o_s_axis_tx_tdata  (tdata),
        .o_s_axis_tx_tkeep  (tkeep),
        .o_s_axis_tx_tlast  (tlast),
        .o_s_axis_tx_tvalid (tvalid),
        .i_s_axis_tx_tready (tready),
        .o_s_axis_tx_tuser  (tuser),
        .i_req_compl        (req_compl),
        .i_req_compl_wd     (req_compl_wd),
        .o_compl_done       (compl_done),
        .i_req_tc           (req_tc),
        .i_req_td           (req_td),
        .i_req_ep           (req_ep),
        .i_req_attr         (req_attr),
        .i_req_len          (req_len),
        .i_req_rid          (req_rid),
        .i_req_tag          (req_tag),
        .i_req_be           (req_be),
        .i_req_addr         (req_addr),
        .i_completer_id     (completer_id),
        .i_resp_mem_valid   (mem_valid),
        .i_resp_mem_data    (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic wd, input logic [2:0] tc, input logic td,
                           input logic ep, input logic [1:0] attr, input logic [15:0] rid,
                           input logic [7:0] tag, input logic [3:0] be,
                           input logic [12:0] addr, input logic [15:0] cid,
                           input logic [63:0] data);
        req_compl_wd = wd;
        req_tc       = tc;
        req_td       = td;
        req_ep       = ep;
        req_attr     = attr;
        req_len      = 10'd1;
        req_rid      = rid;
        req_tag      = tag;
        req_be       = {4'h0, be};
        req_addr     = addr;
        completer_id = cid;
        mem_data     = data;
    endtask

    // One full completion with tready held high; checks both beats and done timing.
    task automatic do_tlp(input string tag, input logic [63:0] exp0,
                          input logic [63:0] exp1, input logic [7:0] keep1);
        tready    = 1'b1;
        req_compl = 1'b1;
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        chk({tag, " b0 valid"}, {63'd0, tvalid}, 64'd1);
        chk({tag, " b0 data"}, tdata, exp0);
        chk({tag, " b0 keep"}, {56'd0, tkeep}, 64'hFF);
        chk({tag, " b0 last"}, {63'd0, tlast}, 64'd0);
        tick();
        chk({tag, " b1 valid"}, {63'd0, tvalid}, 64'd1);
        chk({tag, " b1 data"}, tdata, exp1);
        chk({tag, " b1 keep"}, {56'd0, tkeep}, {56'd0, keep1});
        chk({tag, " b1 last"}, {63'd0, tlast}, 64'd1);
        chk({tag, " b1 nodone"}, {63'd0, compl_done}, 64'd0);
        tick();
        chk({tag, " done"}, {63'd0, compl_done}, 64'd1);
        chk({tag, " done novalid"}, {63'd0, tvalid}, 64'd0);
        req_compl = 1'b0;
        tick();
        chk({tag, " done low"}, {63'd0, compl_done}, 64'd0);
    endtask

    localparam logic [63:0] T1_B0 = 64'h0200_0004_4A00_0001;
    localparam logic [63:0] T1_B1 = 64'h4433_2211_0100_0504;

    initial begin
        int bc_tab [16] = '{1, 1, 1, 2, 1, 3, 2, 3, 1, 4, 3, 4, 2, 4, 3, 4};
        logic [3:0]  be4;
        logic [1:0]  a2;
        logic [11:0] bc12;
        logic [63:0] exp0;
        logic [63:0] exp1;

        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        tready    = 1'b1;
        req_compl = 1'b0;
        mem_valid = 1'b0;
        set_req(1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0, 8'h0, 4'h0, 13'h0, 16'h0, 64'h0);

        // Reset state
        tick();
        tick();
        chk("rst tvalid", {63'd0, tvalid}, 64'd0);
        chk("rst tlast", {63'd0, tlast}, 64'd0);
        chk("rst tdata", tdata, 64'd0);
        chk("rst tkeep", {56'd0, tkeep}, 64'd0);
        chk("rst done", {63'd0, compl_done}, 64'd0);
        chk("rst tuser", {60'd0, tuser}, 64'd0);
        rst = 1'b0;
        tick();

        // 1: CplD reference TLP
        set_req(1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0100, 8'h05, 4'hF, 13'h0104, 16'h0200,
                64'h1122_3344_AABB_CCDD);
        do_tlp("cpld", T1_B0, T1_B1, 8'hFF);

        // 1b: CplD with non-zero header fields, upper data DW, 2-byte span
        set_req(1'b1, 3'd5, 1'b1, 1'b1, 2'd3, 16'hABCD, 8'h7E, 4'b0110, 13'h0016, 16'h1234,
                64'hDEAD_BEEF_0123_4567);
        do_tlp("cpld fields", 64'h1234_0002_4A50_F001, 64'hEFBE_ADDE_ABCD_7E16, 8'hFF);

        // 2: Cpl without data
        set_req(1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0100, 8'h06, 4'hF, 13'h0104, 16'h0200,
                64'h1122_3344_AABB_CCDD);
        do_tlp("cpl", 64'h0200_0004_0A00_0000, 64'h0000_0000_0100_0600, 8'h0F);
        chk("tuser zero", {60'd0, tuser}, 64'd0);

        // 3: backpressure on both beats
        set_req(1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0100, 8'h05, 4'hF, 13'h0104, 16'h0200,
                64'h1122_3344_AABB_CCDD);
        req_compl = 1'b1;
        mem_valid = 1'b1;
        tready    = 1'b0;
        tick();
        mem_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp b0 valid", {63'd0, tvalid}, 64'd1);
            chk("bp b0 data", tdata, T1_B0);
            chk("bp b0 keep", {56'd0, tkeep}, 64'hFF);
            chk("bp b0 last", {63'd0, tlast}, 64'd0);
            chk("bp b0 nodone", {63'd0, compl_done}, 64'd0);
            tick();
        end
        tready = 1'b1;
        tick();
        tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp b1 valid", {63'd0, tvalid}, 64'd1);
            chk("bp b1 data", tdata, T1_B1);
            chk("bp b1 keep", {56'd0, tkeep}, 64'hFF);
            chk("bp b1 last", {63'd0, tlast}, 64'd1);
            chk("bp b1 nodone", {63'd0, compl_done}, 64'd0);
            tick();
        end
        tready = 1'b1;
        tick();
        chk("bp done", {63'd0, compl_done}, 64'd1);
        req_compl = 1'b0;
        tick();
        chk("bp done once", {63'd0, compl_done}, 64'd0);
        tick();
        chk("bp idle", {63'd0, compl_done | tvalid}, 64'd0);

        // 4: first-BE sweep with lower address offsets
        for (int i = 0; i < 16; i++) begin
            be4  = 4'(i);
            a2   = 2'(i);
            bc12 = 12'(bc_tab[i]);
            set_req(1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0100, 8'(i), be4,
                    {6'b000000, 5'b10000, a2}, 16'h0200, 64'h1122_3344_AABB_CCDD);
            exp0 = {16'h0200, 4'h0, bc12, 32'h4A00_0001};
            exp1 = {32'hDDCC_BBAA, 16'h0100, 8'(i), 1'b0, 5'b10000, a2};
            do_tlp($sformatf("be sweep %0d", i), exp0, exp1, 8'hFF);
        end

        // 5: reset during beat 1, then a clean TLP
        set_req(1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0100, 8'h05, 4'hF, 13'h0104, 16'h0200,
                64'h1122_3344_AABB_CCDD);
        req_compl = 1'b1;
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        tick();
        chk("abort in b1", {63'd0, tlast & tvalid}, 64'd1);
        rst = 1'b1;
        tick();
        chk("abort tvalid", {63'd0, tvalid}, 64'd0);
        chk("abort nodone", {63'd0, compl_done}, 64'd0);
        rst       = 1'b0;
        req_compl = 1'b0;
        tick();
        chk("abort nodone2", {63'd0, compl_done}, 64'd0);
        chk("abort idle", {63'd0, tvalid}, 64'd0);
        do_tlp("after abort", T1_B0, T1_B1, 8'hFF);

        // 6a: memory strobe without completion request
        req_compl = 1'b0;
        mem_valid = 1'b1;
        tick();
        chk("posted no tlp", {63'd0, tvalid}, 64'd0);
        tick();
        chk("posted no tlp2", {63'd0, tvalid | compl_done}, 64'd0);
        mem_valid = 1'b0;
        tick();

        // 6b: second trigger while busy is ignored
        req_compl = 1'b1;
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        tready    = 1'b0;
        set_req(1'b1, 3'd7, 1'b1, 1'b1, 2'd3, 16'hBEEF, 8'hAA, 4'h1, 13'h0000, 16'hFFFF,
                64'h5555_6666_7777_8888);
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        chk("busy b0 data", tdata, T1_B0);
        tready = 1'b1;
        tick();
        chk("busy b1 data", tdata, T1_B1);
        tick();
        chk("busy done", {63'd0, compl_done}, 64'd1);
        req_compl = 1'b0;
        tick();
        chk("busy no retrig", {63'd0, tvalid | compl_done}, 64'd0);
        tick();
        chk("busy no retrig2", {63'd0, tvalid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
